// File: rtl/red_isa_pkg.sv
// red_isa_pkg
// Shared definitions for the Red datapath ISA, used by the instruction ROM,
// the fetch/issue sequencer and the execute stage.
//   - ADDR_W / INSTR_W : ROM address and instruction word widths
//   - OP_*             : 4-bit opcode values (OP_BR and OP_HALT are resolved
//                        in fetch, every other opcode belongs to execute)
//   - *_MSB / *_LSB    : instruction field slices
//   - BR_COND_BIT      : BR word bit that selects branch-if-zero
package red_isa_pkg;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 16;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RA_MSB  = 11;
    localparam int RA_LSB  = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    localparam int BR_COND_BIT = 8;

    localparam logic [3:0] OP_LD   = 4'h0;
    localparam logic [3:0] OP_ST   = 4'h1;
    localparam logic [3:0] OP_INC  = 4'h2;
    localparam logic [3:0] OP_BR   = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_AND  = 4'h7;
    localparam logic [3:0] OP_XOR  = 4'h8;
    localparam logic [3:0] OP_SHR  = 4'h9;
    localparam logic [3:0] OP_MOV  = 4'hA;
    localparam logic [3:0] OP_EXCH = 4'hB;
    localparam logic [3:0] OP_CMP  = 4'hC;
    localparam logic [3:0] OP_SET  = 4'hD;
    localparam logic [3:0] OP_CLR  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Extracts the opcode field from a full instruction word.
    function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] word);
        return word[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if
// Bundles the sequencer's ROM port, its issue handshake toward execute, and
// the execute-side control inputs.
//   master (sequencer): drives rom_addr, instr_valid, opcode, ra, imm, halted;
//                       samples rom_data, instr_ready, z_flag, restart
//   slave  (ROM/execute side): the mirror image
interface instr_fetch_if;
    import red_isa_pkg::*;

    logic [ADDR_W-1:0]  rom_addr;
    logic [INSTR_W-1:0] rom_data;
    logic               instr_valid;
    logic               instr_ready;
    logic [3:0]         opcode;
    logic [3:0]         ra;
    logic [7:0]         imm;
    logic               z_flag;
    logic               restart;
    logic               halted;

    modport master (
        output rom_addr, instr_valid, opcode, ra, imm, halted,
        input  rom_data, instr_ready, z_flag, restart
    );

    modport slave (
        input  rom_addr, instr_valid, opcode, ra, imm, halted,
        output rom_data, instr_ready, z_flag, restart
    );

endinterface

// File: rtl/instr_fetch_program_counter.sv
// program_counter
// 8-bit program counter register with asynchronous active-high reset.
//   clk, reset  : clock and async reset (reset value 0)
//   clear       : synchronous clear to 0 (highest priority)
//   load        : load load_value (beats increment)
//   inc         : increment by one, wrapping 0xFF -> 0x00
//   value       : current counter value
module program_counter
    import red_isa_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_value,
    input  logic              inc,
    output logic [ADDR_W-1:0] value
);

    // Priority chain clear > load > inc; the add wraps naturally at 8 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (inc) begin
            value <= value + 1'b1;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch
// Fetch/issue sequencer for the Red datapath. Owns the PC, reads the
// combinational instruction ROM, issues opcode/ra/imm to execute over a
// valid/ready handshake, and resolves BR and HALT locally.
//   clk    : clock, all state changes on the rising edge
//   reset  : asynchronous active-high reset
//   bus    : instr_fetch_if master modport (ROM port, issue handshake,
//            z_flag, restart, halted)
module instr_fetch
    import red_isa_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    instr_fetch_if.master bus
);

    typedef enum logic [1:0] {
        S_RUN_FETCH = 2'd0,
        S_ISSUE     = 2'd1,
        S_HALT      = 2'd2
    } state_t;

    state_t              state;
    logic [INSTR_W-1:0]  ir;
    logic                valid_q;
    logic                halted_q;
    logic [ADDR_W-1:0]   pc;

    logic                fetch_is_halt;
    logic                handshake;
    logic                branch_taken;
    logic                pc_inc;
    logic                pc_load;

    // A HALT word is recognised straight off the ROM so it is never latched
    // into ir and never issued.
    assign fetch_is_halt = (opcode_of(bus.rom_data) == OP_HALT);
    assign handshake     = (state == S_ISSUE) && bus.instr_ready;

    // BR is unconditional when the condition bit is clear, otherwise taken
    // only when execute reports zero in the handshake cycle.
    assign branch_taken  = (opcode_of(ir) == OP_BR) &&
                           (!ir[BR_COND_BIT] || bus.z_flag);

    // Restart drives the counter's clear, which outranks both of these, so
    // a branch target accepted together with restart is dropped there.
    assign pc_inc  = (state == S_RUN_FETCH) && !fetch_is_halt;
    assign pc_load = handshake && branch_taken;

    program_counter u_pc (
        .clk        (clk),
        .reset      (reset),
        .clear      (bus.restart),
        .load       (pc_load),
        .load_value (ir[IMM_MSB:IMM_LSB]),
        .inc        (pc_inc),
        .value      (pc)
    );

    // Sequencer state plus registered valid/halted flags. The fields come
    // from ir, so they stay stable for the whole time ISSUE is stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_RUN_FETCH;
            ir       <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else if (bus.restart) begin
            state    <= S_RUN_FETCH;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            case (state)
                S_RUN_FETCH: begin
                    if (fetch_is_halt) begin
                        state    <= S_HALT;
                        halted_q <= 1'b1;
                    end else begin
                        ir      <= bus.rom_data;
                        state   <= S_ISSUE;
                        valid_q <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (bus.instr_ready) begin
                        state   <= S_RUN_FETCH;
                        valid_q <= 1'b0;
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state    <= S_RUN_FETCH;
                    valid_q  <= 1'b0;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rom_addr    = pc;
    assign bus.instr_valid = valid_q;
    assign bus.halted      = halted_q;
    assign bus.opcode      = ir[OPC_MSB:OPC_LSB];
    assign bus.ra          = ir[RA_MSB:RA_LSB];
    assign bus.imm         = ir[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch
// Self-checking bench for instr_fetch: a ROM array answers rom_addr
// combinationally, and an instruction-level reference model predicts every
// output each cycle. Directed programs cover the main scenarios, then a
// randomized program with random ready/z_flag/restart runs for a while.
module tb_instr_fetch;

    logic clk;
    logic reset;

    logic [15:0] rom [256];

    int tests;
    int failures;

    // Reference model state
    logic [7:0]  m_pc;
    logic [15:0] m_ir;
    bit          m_issuing;
    bit          m_halted;

    instr_fetch_if bus();

    instr_fetch dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.rom_data = rom[bus.rom_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts one comparison and reports it when the values differ.
    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Compares every DUT output with the reference model.
    task automatic checkAll(input string tag);
        checkOutput({tag, ".addr"},   16'(bus.rom_addr),    16'(m_pc));
        checkOutput({tag, ".valid"},  16'(bus.instr_valid), 16'(m_issuing));
        checkOutput({tag, ".halted"}, 16'(bus.halted),      16'(m_halted));
        checkOutput({tag, ".opcode"}, 16'(bus.opcode),      16'(m_ir[15:12]));
        checkOutput({tag, ".ra"},     16'(bus.ra),          16'(m_ir[11:8]));
        checkOutput({tag, ".imm"},    16'(bus.imm),         16'(m_ir[7:0]));
    endtask

    // One instruction-level step of the sequencer's behaviour.
    task automatic modelStep(input bit ready, input bit z, input bit rs);
        logic [15:0] w;
        if (rs) begin
            m_pc      = 8'h00;
            m_issuing = 1'b0;
            m_halted  = 1'b0;
        end else if (m_halted) begin
            m_halted = 1'b1;
        end else if (!m_issuing) begin
            w = rom[m_pc];
            if (w[15:12] == 4'hF) begin
                m_halted = 1'b1;
            end else begin
                m_ir      = w;
                m_pc      = m_pc + 8'd1;
                m_issuing = 1'b1;
            end
        end else if (ready) begin
            if (m_ir[15:12] == 4'h3 && (!m_ir[8] || z))
                m_pc = m_ir[7:0];
            m_issuing = 1'b0;
        end
    endtask

    // Drives one cycle of inputs, advances the model, and checks after the edge.
    task automatic applyStimulus(input bit ready, input bit z, input bit rs, input string tag);
        bus.instr_ready = ready;
        bus.z_flag      = z;
        bus.restart     = rs;
        modelStep(ready, z, rs);
        @(posedge clk);
        @(negedge clk);
        checkAll(tag);
    endtask

    task automatic doReset();
        bus.instr_ready = 1'b0;
        bus.z_flag      = 1'b0;
        bus.restart     = 1'b0;
        reset = 1'b1;
        m_pc      = 8'h00;
        m_ir      = 16'h0000;
        m_issuing = 1'b0;
        m_halted  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checkAll("reset");
    endtask

    task automatic clearRom();
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    endtask

    int valid_count;

    initial begin
        tests    = 0;
        failures = 0;
        reset    = 1'b1;
        bus.instr_ready = 1'b0;
        bus.z_flag      = 1'b0;
        bus.restart     = 1'b0;
        clearRom();
        @(negedge clk);

        // Straight-line program ending in HALT, ready tied high
        clearRom();
        rom[0] = 16'h4000; rom[1] = 16'h4000; rom[2] = 16'h5000;
        rom[3] = 16'h5000; rom[4] = 16'hFFFF;
        doReset();
        valid_count = 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, "straight");
            if (bus.instr_valid) valid_count++;
        end
        checkOutput("straight.valid_count", 16'(valid_count), 16'd4);
        checkOutput("straight.halt_addr", 16'(bus.rom_addr), 16'h0004);
        checkOutput("straight.halted", 16'(bus.halted), 16'h0001);

        // Backpressure on the first issue
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, "bp.fetch");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, "bp.stall");
            checkOutput("bp.hold_valid",  16'(bus.instr_valid), 16'h0001);
            checkOutput("bp.hold_opcode", 16'(bus.opcode),      16'h0004);
            checkOutput("bp.hold_addr",   16'(bus.rom_addr),    16'h0001);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, "bp.accept");
        applyStimulus(1'b1, 1'b0, 1'b0, "bp.next");
        checkOutput("bp.next_addr", 16'(bus.rom_addr), 16'h0002);

        // Unconditional branch
        clearRom();
        rom[0] = 16'h3010; rom[8'h10] = 16'h7ABC;
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, "br.fetch");
        applyStimulus(1'b1, 1'b0, 1'b0, "br.take");
        checkOutput("br.target", 16'(bus.rom_addr), 16'h0010);
        applyStimulus(1'b1, 1'b0, 1'b0, "br.fetch_tgt");
        checkOutput("br.tgt_opcode", 16'(bus.opcode), 16'h0007);
        checkOutput("br.tgt_imm",    16'(bus.imm),    16'h00BC);

        // Conditional branch, not taken and taken
        clearRom();
        rom[0] = 16'h3120;
        for (int zz = 0; zz < 2; zz++) begin
            doReset();
            applyStimulus(1'b1, 1'b0, 1'b0, "bz.fetch");
            applyStimulus(1'b1, zz[0], 1'b0, "bz.hs");
            checkOutput(zz == 0 ? "bz.z0_addr" : "bz.z1_addr", 16'(bus.rom_addr),
                        zz == 0 ? 16'h0001 : 16'h0020);
        end

        // Branch to 0xFF, then PC wraps to 0x00
        clearRom();
        rom[0] = 16'h30FF; rom[8'hFF] = 16'h6000;
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, "wrap.fetch");
        applyStimulus(1'b1, 1'b0, 1'b0, "wrap.br");
        applyStimulus(1'b1, 1'b0, 1'b0, "wrap.fetch_ff");
        checkOutput("wrap.opcode", 16'(bus.opcode), 16'h0006);
        applyStimulus(1'b1, 1'b0, 1'b0, "wrap.hs");
        checkOutput("wrap.addr", 16'(bus.rom_addr), 16'h0000);

        // Async reset while an instruction waits in ISSUE
        clearRom();
        rom[0] = 16'h4000; rom[1] = 16'h5123;
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, "ar.fetch");
        applyStimulus(1'b1, 1'b0, 1'b0, "ar.hs");
        applyStimulus(1'b0, 1'b0, 1'b0, "ar.fetch2");
        #2 reset = 1'b1;
        #1;
        checkOutput("ar.valid", 16'(bus.instr_valid), 16'h0000);
        checkOutput("ar.addr",  16'(bus.rom_addr),    16'h0000);
        checkOutput("ar.opcode", 16'(bus.opcode),     16'h0000);
        m_pc = 8'h00; m_ir = 16'h0000; m_issuing = 1'b0; m_halted = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        checkAll("ar.after");

        // Restart out of HALT
        clearRom();
        rom[0] = 16'h4000; rom[1] = 16'hF000;
        doReset();
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, "rh.run");
        checkOutput("rh.halted", 16'(bus.halted), 16'h0001);
        checkOutput("rh.halt_addr", 16'(bus.rom_addr), 16'h0001);
        applyStimulus(1'b1, 1'b0, 1'b1, "rh.restart");
        checkOutput("rh.cleared", 16'(bus.halted), 16'h0000);
        checkOutput("rh.addr0", 16'(bus.rom_addr), 16'h0000);
        applyStimulus(1'b1, 1'b0, 1'b0, "rh.refetch");

        // Randomized program with random handshake, z_flag and restart
        for (int i = 0; i < 256; i++) begin
            rom[i] = 16'($urandom);
            if ($urandom_range(0, 31) == 0)
                rom[i][15:12] = 4'hF;
            else if ($urandom_range(0, 3) == 0 || rom[i][15:12] == 4'hF)
                rom[i][15:12] = 4'h3;
        end
        doReset();
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 29) == 0, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch/issue sequencer for the Red datapath. It is the consumer side of the 256×16 instruction ROM: it owns the program counter, drives the ROM address, and captures the combinational ROM word. It splits the word into opcode and operand fields and hands them to the execute stage over a valid/ready handshake. It resolves BR (opcode 3) and HALT (opcode F) locally.

## Interface
- No parameters. Widths are fixed by the ISA: 8-bit address, 16-bit instruction word.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `rom_addr` out 8: ROM address; always equals the PC register.
- `rom_data` in 16: ROM word; valid combinationally in the same cycle as `rom_addr`.
- `instr_valid` out 1: issued instruction fields are valid.
- `instr_ready` in 1: execute stage accepts the issued instruction.
- `opcode` out 4: `ir[15:12]`.
- `ra` out 4: `ir[11:8]`.
- `imm` out 8: `ir[7:0]`.
- `z_flag` in 1: zero flag from the execute stage, used for conditional BR.
- `restart` in 1: synchronous pulse that clears the PC and resumes fetching.
- `halted` out 1: the sequencer is in the HALT state.

## Operation
- Registers: `pc` [7:0], `ir` [15:0], and the state register.
- States are RUN_FETCH, ISSUE and HALT.
- Reset values: state RUN_FETCH, pc 0x00, ir 0x0000. Outputs: `rom_addr` 0, `instr_valid` 0, `opcode`/`ra`/`imm` 0, `halted` 0.
- RUN_FETCH: `rom_addr` = pc.
  - If `rom_data[15:12]` == 0xF, the next state is HALT. `pc` and `ir` stay unchanged; the HALT word is never issued.
  - Otherwise `ir` <= `rom_data`, `pc` <= pc+1 (mod 256, so 0xFF wraps to 0x00), and the next state is ISSUE.
- ISSUE: `instr_valid` = 1, and the fields are driven from `ir`, stable while waiting. On `instr_valid && instr_ready`:
  - If opcode == 3 and (`ir[8]` == 0 or `z_flag` == 1), `pc` <= `ir[7:0]`. `z_flag` is sampled in the handshake cycle. `ir[8]` = 1 selects branch-if-zero.
  - Otherwise `pc` keeps its incremented value.
  - Next state is RUN_FETCH.
- Without `instr_ready`, the sequencer holds ISSUE and all outputs are unchanged.
- HALT: `halted` = 1 and `instr_valid` = 0. `rom_addr` holds the address of the HALT word. The sequencer stays here until `restart` or `reset`.
- `restart` in any state sets `pc` <= 0 and next state RUN_FETCH, and has priority over every other transition.
  - If `restart` coincides with an ISSUE handshake, the instruction counts as accepted, but any branch target is discarded.
- `reset` mid-operation immediately forces all registers to their reset values, regardless of `clk`.
- Opcodes 0–2 and 4–E are passed through undecoded. Their meaning (LD, ST, INC, ADD, SUB, OR, AND, XOR, SHR, MOV, EXCH, CMP, SET, CLR) belongs to the execute stage.

## Timing
- The first fetch is the cycle after `reset` deasserts, with `rom_addr` = 0. `instr_valid` rises on the next cycle.
- Minimum issue interval is 2 cycles per instruction: one RUN_FETCH cycle plus one ISSUE cycle with `instr_ready` high.
- Branch penalty is zero extra cycles: the target is fetched in the cycle immediately after the handshake.
- HALT is reached 1 cycle after the HALT word appears on `rom_data`. `halted` is registered, so it is visible in that next cycle.
- After `restart`, the fetch from address 0 happens in the following cycle.

## Structure
- Shared package `red_isa_pkg` holds:
  - opcode constants OP_LD=0 … OP_CLR=4'hE and OP_HALT=4'hF;
  - field slices (OPC_MSB/LSB, RA_MSB/LSB, IMM_MSB/LSB) and the BR condition bit index (8);
  - ADDR_W=8 and INSTR_W=16, reused by the ROM and the execute stage.
- The state encoding is local to this block.
- One sub-module, `program_counter`, provides:
  - an 8-bit register with async reset;
  - load-enable plus load value, increment-enable, and clear;
  - priority clear > load > increment.
- Remaining target size is roughly 150–250 lines of RTL.

## Test plan
- Program ROM with 0x4000, 0x4000, 0x5000, 0x5000, then 0xFFFF, with `instr_ready` tied high. Required: opcodes 4, 4, 5, 5 issued from addresses 0–3, with `instr_valid` high every other cycle; then `halted` = 1 with `rom_addr` = 4, and no valid is raised for the HALT word.
- Backpressure: hold `instr_ready` low for 3 cycles on the first issue. Required: `instr_valid`, `opcode` = 4 and `rom_addr` = 1 are all held stable; the next fetch occurs only after `instr_ready` goes high.
- Put 0x3010 (unconditional BR) at address 0. Required: the next `rom_addr` is 0x10, and the word at 0x10 is issued.
- Put 0x3120 at address 0.
  - With `z_flag` = 0 at the handshake, the next `rom_addr` is 0x01.
  - Rerun with `z_flag` = 1: the next `rom_addr` is 0x20.
- Wrap: branch to 0xFF, where 0xFF holds 0x6000. Required: opcode 6 issues, then `rom_addr` = 0x00.
- Assert `reset` asynchronously mid-ISSUE. Required: `instr_valid` = 0 and `rom_addr` = 0 before the next edge.
- Separately, pulse `restart` in HALT. Required: `halted` = 0 and `rom_addr` = 0 on the next cycle.
